// File: rtl/conv2_relu_pool_if.sv
// Stream bus between the conv2 calculation block and the bias/ReLU/max-pool
// stage: a qualified input pixel stream and a qualified pooled output stream.
interface conv2_relu_pool_if #(
  parameter int DW = 14
);
  logic                 valid_i;
  logic signed [DW-1:0] data_i;
  logic                 valid_o;
  logic signed [DW-1:0] data_o;
  logic                 frame_done_o;

  // Upstream/test side: drives pixels, observes pooled samples
  modport master (
    output valid_i, data_i,
    input  valid_o, data_o, frame_done_o
  );

  // Pool stage side: consumes pixels, produces pooled samples
  modport slave (
    input  valid_i, data_i,
    output valid_o, data_o, frame_done_o
  );
endinterface

// File: rtl/conv2_relu_pool.sv
// conv2_relu_pool: adds a per-channel bias to the conv2 result stream, applies
// ReLU, then performs a 2x2 stride-2 max-pool over an IMG_W x IMG_H map.
// Even rows store their pair-maxima in a half-width row buffer; odd rows
// combine with it and emit one pooled sample per window, two cycles after the
// window's bottom-right pixel.
// Optional build macro CONV2_POOL_SAT_EN: saturate the biased sum to the DW-bit
// signed range instead of wrapping it.
module conv2_relu_pool #(
  parameter int                   DW    = 14,
  parameter int                   IMG_W = 8,
  parameter int                   IMG_H = 8,
  parameter logic signed [DW-1:0] BIAS  = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  conv2_relu_pool_if.slave bus_if
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int BW = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic {
    EVEN_ROW = 1'b0,
    ODD_ROW  = 1'b1
  } state_t;

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Reduce the DW+1 bit biased sum to DW bits and clamp negatives to zero.
  function automatic logic signed [DW-1:0] narrow_relu(input logic [DW:0] s);
    logic signed [DW-1:0] n;
`ifdef CONV2_POOL_SAT_EN
    if (s[DW] != s[DW-1]) begin
      n = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      n = s[DW-1:0];
    end
`else
    n = s[DW-1:0];
`endif
    return n[DW-1] ? {DW{1'b0}} : n;
  endfunction

  state_t               state_q, state_d;
  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;

  logic                 v1_q;
  logic signed [DW-1:0] r1_q;
  logic [CW-1:0]        col1_q;
  logic [RW-1:0]        row1_q;
  state_t               st1_q;

  logic signed [DW-1:0] h_q;
  logic                 valid_q;
  logic signed [DW-1:0] data_q;
  logic                 done_q;
  logic signed [DW-1:0] rowbuf_q [IMG_W/2];

  logic [DW:0]          sum_s;
  logic [BW-1:0]        idx_s;
  logic signed [DW-1:0] m_s;
  logic signed [DW-1:0] pool_s;

  assign sum_s  = {bus_if.data_i[DW-1], bus_if.data_i} + {BIAS[DW-1], BIAS};
  assign idx_s  = BW'(col1_q >> 1);
  assign m_s    = smax(h_q, r1_q);
  assign pool_s = smax(rowbuf_q[idx_s], m_s);

  assign bus_if.valid_o      = valid_q;
  assign bus_if.data_o       = data_q;
  assign bus_if.frame_done_o = done_q;

  // Row-parity state and raster position register for incoming pixels
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EVEN_ROW;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Next raster position; row parity toggles at the end of every row
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (bus_if.valid_i) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? {RW{1'b0}} : row_q + {{(RW-1){1'b0}}, 1'b1};
        case (state_q)
          EVEN_ROW: state_d = ODD_ROW;
          ODD_ROW:  state_d = EVEN_ROW;
          default:  state_d = EVEN_ROW;
        endcase
      end else begin
        col_d = col_q + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      state_d = state_q;
    end
  end

  // Bias + ReLU stage; the pixel's position and row parity travel alongside
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q   <= 1'b0;
      r1_q   <= '0;
      col1_q <= '0;
      row1_q <= '0;
      st1_q  <= EVEN_ROW;
    end else begin
      v1_q <= bus_if.valid_i;
      if (bus_if.valid_i) begin
        r1_q   <= narrow_relu(sum_s);
        col1_q <= col_q;
        row1_q <= row_q;
        st1_q  <= state_q;
      end
    end
  end

  // Horizontal pair hold and pooled output register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q     <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      if (v1_q) begin
        if (!col1_q[0]) begin
          h_q <= r1_q;
        end else if (st1_q == ODD_ROW) begin
          valid_q <= 1'b1;
          data_q  <= pool_s;
          done_q  <= (row1_q == ROW_LAST) && (col1_q == COL_LAST);
        end
      end
    end
  end

  // Even-row pair maxima; every entry is written before the odd row reads it
  always_ff @(posedge clk_i) begin
    if (v1_q && col1_q[0] && (st1_q == EVEN_ROW)) begin
      rowbuf_q[idx_s] <= m_s;
    end
  end

endmodule
